// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: FSM state encoding,
// sequential step sizes and the target-alignment mask helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_e;

  localparam int unsigned STEP_WORD = 4;
  localparam int unsigned STEP_HALF = 2;

  // Low PC bits that must be zero in an applied target: bit[0] when 16-bit
  // instructions exist, bits[1:0] otherwise.
  function automatic logic [1:0] low_mask(input logic has_compressed);
    return has_compressed ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect target selection (trap over branch), alignment, and the single-entry
// pending-redirect buffer that holds a target while the fetch request stalls.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned HAS_COMPRESSED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            capture_en,
  input  logic            clear,
  output logic            tgt_valid,
  output logic [XLEN-1:0] tgt_pc,
  output logic            tgt_misalign,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_pc
);

  localparam logic [1:0] LOW_MASK = low_mask(HAS_COMPRESSED != 0);

  logic [XLEN-1:0] raw_pc;

  // Trap wins over a same-cycle branch redirect; the redirect is dropped.
  always_comb begin
    raw_pc = trap_valid ? trap_pc : redirect_pc;
  end

  assign tgt_valid    = trap_valid | redirect_valid;
  assign tgt_pc       = {raw_pc[XLEN-1:2], raw_pc[1:0] & ~LOW_MASK};
  assign tgt_misalign = |(raw_pc[1:0] & LOW_MASK);

  // Pending entry: cleared by any accept, newest stalled target overwrites.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (capture_en && tgt_valid) begin
      pend_valid <= 1'b1;
      pend_pc    <= tgt_pc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: reset vector, valid/ready
// handshake with stall hold, prioritised redirects and halt/resume control.
//
//  state  | meaning
//  BOOT   | first cycle after reset, no request offered
//  RUN    | requests offered, PC advances on accept
//  DRAIN  | halt seen, finishing the outstanding request
//  HALTED | no requests; redirects load the PC directly
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
  parameter int unsigned     HAS_COMPRESSED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            seq_half,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic            halted,
  output logic            misalign_flag
);

  pc_state_e       state;
  logic            accept;
  logic            active;
  logic            tgt_valid;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_misalign;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] step;

  assign accept = fetch_valid & fetch_ready;
  assign active = (state == ST_RUN) || (state == ST_DRAIN);
  assign step   = ((HAS_COMPRESSED != 0) && seq_half) ? XLEN'(STEP_HALF)
                                                      : XLEN'(STEP_WORD);

  pc_redirect_buf #(
    .XLEN           (XLEN),
    .HAS_COMPRESSED (HAS_COMPRESSED)
  ) u_redirect_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .capture_en     (active && !accept),
    .clear          (accept),
    .tgt_valid      (tgt_valid),
    .tgt_pc         (tgt_pc),
    .tgt_misalign   (tgt_misalign),
    .pend_valid     (pend_valid),
    .pend_pc        (pend_pc)
  );

  // Fetch FSM with registered handshake/status outputs and the PC adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_BOOT;
      fetch_pc      <= RESET_VECTOR;
      fetch_valid   <= 1'b0;
      halted        <= 1'b0;
      misalign_flag <= 1'b0;
    end else begin
      misalign_flag <= 1'b0;
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN, ST_DRAIN: begin
          if (accept) begin
            if (tgt_valid)       fetch_pc <= tgt_pc;
            else if (pend_valid) fetch_pc <= pend_pc;
            else                 fetch_pc <= fetch_pc + step;
          end
          // Flag on capture, whether the target lands in the PC or in pending.
          if (tgt_valid) misalign_flag <= tgt_misalign;
          if (state == ST_RUN) begin
            if (halt_req) state <= ST_DRAIN;
          end else if (accept) begin
            state       <= ST_HALTED;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (tgt_valid) begin
            fetch_pc      <= tgt_pc;
            misalign_flag <= tgt_misalign;
          end
          if (trap_valid || resume_req) begin
            state       <= ST_RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a word-only instance with a high reset vector and
// a compressed-capable instance share all inputs.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready;
  logic        seq_half;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        resume_req;

  logic        fetch_valid, halted, misalign_flag;
  logic [31:0] fetch_pc;
  logic        c_fetch_valid, c_halted, c_misalign_flag;
  logic [31:0] c_fetch_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .HAS_COMPRESSED(0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .seq_half(seq_half), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halt_req(halt_req), .resume_req(resume_req), .halted(halted),
    .misalign_flag(misalign_flag)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .HAS_COMPRESSED(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .fetch_valid(c_fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(c_fetch_pc), .seq_half(seq_half), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halt_req(halt_req), .resume_req(resume_req), .halted(c_halted),
    .misalign_flag(c_misalign_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steer both instances to a known PC with an accepted redirect.
  task automatic goto(input logic [31:0] addr);
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", fetch_valid); end
    n_cmp++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc got %h want 80000000", fetch_pc); end
    n_cmp++; if (halted !== 1'b0 || misalign_flag !== 1'b0) begin n_err++; $display("FAIL reset_status got halted=%0b mis=%0b want 0/0", halted, misalign_flag); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL boot_first got v=%0b pc=%h want 1/80000000", fetch_valid, fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h8000_0004) begin n_err++; $display("FAIL boot_seq1 got %h want 80000004", fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h8000_0008) begin n_err++; $display("FAIL boot_seq2 got %h want 80000008", fetch_pc); end
  endtask

  task automatic test_stall();
    goto(32'h10);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (fetch_pc !== 32'h10 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h want 1/00000010", i, fetch_valid, fetch_pc); end
    end
    fetch_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_pc !== 32'h14) begin n_err++; $display("FAIL stall_release got %h want 00000014", fetch_pc); end
  endtask

  task automatic test_redirect_stall();
    goto(32'h20);
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h20) begin n_err++; $display("FAIL rstall_capture got %h want 00000020", fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h20) begin n_err++; $display("FAIL rstall_hold got %h want 00000020", fetch_pc); end
    fetch_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_pc !== 32'h100) begin n_err++; $display("FAIL rstall_apply got %h want 00000100", fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h104) begin n_err++; $display("FAIL rstall_cleared got %h want 00000104", fetch_pc); end
  endtask

  task automatic test_trap_priority();
    fetch_ready = 1'b1;
    trap_valid = 1'b1; trap_pc = 32'h200;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h200) begin n_err++; $display("FAIL trap_wins got %h want 00000200", fetch_pc); end
    n_cmp++; if (misalign_flag !== 1'b0) begin n_err++; $display("FAIL trap_nomis got %0b want 0", misalign_flag); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h100) begin n_err++; $display("FAIL mis_align got %h want 00000100", fetch_pc); end
    n_cmp++; if (misalign_flag !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %0b want 1", misalign_flag); end
    tick();
    n_cmp++; if (misalign_flag !== 1'b0 || fetch_pc !== 32'h104) begin n_err++; $display("FAIL mis_end got mis=%0b pc=%h want 0/00000104", misalign_flag, fetch_pc); end
  endtask

  task automatic test_halt();
    goto(32'h3C);
    halt_req = 1'b1;
    tick();
    n_cmp++; if (fetch_pc !== 32'h40 || fetch_valid !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL drain_offer got v=%0b h=%0b pc=%h want 1/0/00000040", fetch_valid, halted, fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h44 || fetch_valid !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halted_enter got v=%0b h=%0b pc=%h want 0/1/00000044", fetch_valid, halted, fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h44 || halted !== 1'b1) begin n_err++; $display("FAIL halted_stay got h=%0b pc=%h want 1/00000044", halted, fetch_pc); end
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h44 || fetch_valid !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL resume got v=%0b h=%0b pc=%h want 1/0/00000044", fetch_valid, halted, fetch_pc); end
    tick();
    halt_req = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h48 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL rehalt_drain got v=%0b pc=%h want 1/00000048", fetch_valid, fetch_pc); end
    tick();
    n_cmp++; if (fetch_pc !== 32'h4C || halted !== 1'b1) begin n_err++; $display("FAIL rehalt_done got h=%0b pc=%h want 1/0000004c", halted, fetch_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h80 || halted !== 1'b1 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL halted_redirect got v=%0b h=%0b pc=%h want 0/1/00000080", fetch_valid, halted, fetch_pc); end
    trap_valid = 1'b1; trap_pc = 32'h90;
    tick();
    trap_valid = 1'b0;
    n_cmp++; if (fetch_pc !== 32'h90 || halted !== 1'b0 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL halted_trap got v=%0b h=%0b pc=%h want 1/0/00000090", fetch_valid, halted, fetch_pc); end
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    tick();
    n_cmp++; if (fetch_pc !== 32'h0) begin n_err++; $display("FAIL wrap got %h want 00000000", fetch_pc); end
  endtask

  task automatic test_compressed();
    goto(32'h10);
    seq_half = 1'b1;
    tick();
    seq_half = 1'b0;
    n_cmp++; if (c_fetch_pc !== 32'h12) begin n_err++; $display("FAIL half_step got %h want 00000012", c_fetch_pc); end
    n_cmp++; if (fetch_pc !== 32'h14) begin n_err++; $display("FAIL half_ignored got %h want 00000014", fetch_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (c_fetch_pc !== 32'h102 || c_misalign_flag !== 1'b0) begin n_err++; $display("FAIL c_half_target got pc=%h mis=%0b want 00000102/0", c_fetch_pc, c_misalign_flag); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (c_fetch_pc !== 32'h102 || c_misalign_flag !== 1'b1) begin n_err++; $display("FAIL c_odd_target got pc=%h mis=%0b want 00000102/1", c_fetch_pc, c_misalign_flag); end
  endtask

  task automatic test_reset_mid_stall();
    goto(32'h70);
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_cmp++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h8000_0000 || halted !== 1'b0) begin n_err++; $display("FAIL midreset got v=%0b h=%0b pc=%h want 0/0/80000000", fetch_valid, halted, fetch_pc); end
    rst_n = 1'b1;
    tick();
    fetch_ready = 1'b1;
    tick();
    n_cmp++; if (fetch_pc !== 32'h8000_0004) begin n_err++; $display("FAIL midreset_pending got %h want 80000004", fetch_pc); end
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; seq_half = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0;
    halt_req = 1'b0; resume_req = 1'b0;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_trap_priority();
    test_halt();
    test_wrap();
    test_compressed();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
